// File: rtl/vram_arbiter.sv
// Two-master VRAM arbiter: VGA/CPU burst access to a 16-bit word RAM.
// VGA has fixed priority, with a starvation override for the CPU.
module vram_arbiter #(
   parameter int BUS_WIDTH    = 32,
   parameter int CTRL_WIDTH   = 8,
   parameter int ADDR_BITS    = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  vga_req,
   input  logic [BUS_WIDTH-1:0]  vga_bus_out,
   input  logic [CTRL_WIDTH-1:0] vga_ctrl_out,
   output logic                  vga_ack,
   input  logic                  cpu_req,
   input  logic [BUS_WIDTH-1:0]  cpu_bus_out,
   input  logic [CTRL_WIDTH-1:0] cpu_ctrl_out,
   output logic                  cpu_ack,
   output logic [BUS_WIDTH-1:0]  bus_in,
   output logic [CTRL_WIDTH-1:0] ctrl_in
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      ADDR,
      READ,
      WRITE
   } state_t;

   state_t state, state_nxt;

   logic                 sel_cpu, sel_cpu_nxt;
   logic [ADDR_BITS-1:0] addr, addr_nxt;
   logic [2:0]           len_m1, len_m1_nxt;
   logic [2:0]           cnt, cnt_nxt;
   logic [SW-1:0]        starve, starve_nxt;
   logic                 vga_ack_nxt, cpu_ack_nxt;
   logic                 bus_wait, bus_wait_nxt;
   logic [BUS_WIDTH-1:0] bus_in_nxt;

   logic [15:0] mem [0:(1<<ADDR_BITS)-1];
   logic        mem_we;

   logic [BUS_WIDTH-1:0]  g_bus;
   logic [CTRL_WIDTH-1:0] g_ctrl;
   logic                  cpu_win;
   logic                  last;
   logic                  unused_bits;

   assign g_bus   = sel_cpu ? cpu_bus_out : vga_bus_out;
   assign g_ctrl  = sel_cpu ? cpu_ctrl_out : vga_ctrl_out;
   assign cpu_win = cpu_req && (!vga_req || starve == STARVE_MAX);
   assign last    = (cnt == len_m1);
   assign ctrl_in = CTRL_WIDTH'(bus_wait);

   assign unused_bits = ^{vga_bus_out, cpu_bus_out,
                          vga_ctrl_out, cpu_ctrl_out};

   always_comb begin
      state_nxt    = state;
      sel_cpu_nxt  = sel_cpu;
      addr_nxt     = addr;
      len_m1_nxt   = len_m1;
      cnt_nxt      = cnt;
      starve_nxt   = starve;
      vga_ack_nxt  = 1'b0;
      cpu_ack_nxt  = 1'b0;
      bus_wait_nxt = 1'b1;
      bus_in_nxt   = bus_in;
      mem_we       = 1'b0;
      unique case (state)
         IDLE: begin
            if (vga_req || cpu_req) begin
               state_nxt   = GRANT;
               sel_cpu_nxt = cpu_win;
               if (cpu_win) begin
                  cpu_ack_nxt = 1'b1;
                  starve_nxt  = '0;
               end else begin
                  vga_ack_nxt = 1'b1;
                  if (cpu_req && starve != STARVE_MAX)
                     starve_nxt = starve + SW'(1);
               end
            end
         end
         GRANT: begin
            state_nxt = ADDR;
         end
         ADDR: begin
            addr_nxt   = g_bus[ADDR_BITS-1:0];
            len_m1_nxt = g_ctrl[3:1];
            cnt_nxt    = '0;
            // VGA is read-only: its write bit is ignored
            if (sel_cpu && g_ctrl[0]) begin
               state_nxt    = WRITE;
               bus_wait_nxt = 1'b0;
            end else begin
               state_nxt = READ;
            end
         end
         READ: begin
            bus_in_nxt   = BUS_WIDTH'(mem[addr]);
            bus_wait_nxt = 1'b0;
            addr_nxt     = addr + ADDR_BITS'(1);
            cnt_nxt      = cnt + 3'd1;
            if (last)
               state_nxt = IDLE;
         end
         WRITE: begin
            mem_we   = 1'b1;
            addr_nxt = addr + ADDR_BITS'(1);
            cnt_nxt  = cnt + 3'd1;
            if (last)
               state_nxt = IDLE;
            else
               bus_wait_nxt = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state    <= IDLE;
         sel_cpu  <= 1'b0;
         addr     <= '0;
         len_m1   <= '0;
         cnt      <= '0;
         starve   <= '0;
         vga_ack  <= 1'b0;
         cpu_ack  <= 1'b0;
         bus_wait <= 1'b1;
         bus_in   <= '0;
      end else begin
         state    <= state_nxt;
         sel_cpu  <= sel_cpu_nxt;
         addr     <= addr_nxt;
         len_m1   <= len_m1_nxt;
         cnt      <= cnt_nxt;
         starve   <= starve_nxt;
         vga_ack  <= vga_ack_nxt;
         cpu_ack  <= cpu_ack_nxt;
         bus_wait <= bus_wait_nxt;
         bus_in   <= bus_in_nxt;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[addr] <= cpu_bus_out[15:0];
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: transaction-level timing model,
// randomized traffic and directed burst, priority and reset scenarios.
module tb_vram_arbiter;

   logic        clk;
   logic        reset_L;
   logic        vga_req, cpu_req;
   logic [31:0] vga_bus_out, cpu_bus_out;
   logic [7:0]  vga_ctrl_out, cpu_ctrl_out;
   logic        vga_ack, cpu_ack;
   logic [31:0] bus_in;
   logic [7:0]  ctrl_in;

   vram_arbiter #(
      .BUS_WIDTH(32),
      .CTRL_WIDTH(8),
      .ADDR_BITS(12),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset_L(reset_L),
      .vga_req(vga_req),
      .vga_bus_out(vga_bus_out),
      .vga_ctrl_out(vga_ctrl_out),
      .vga_ack(vga_ack),
      .cpu_req(cpu_req),
      .cpu_bus_out(cpu_bus_out),
      .cpu_ctrl_out(cpu_ctrl_out),
      .cpu_ack(cpu_ack),
      .bus_in(bus_in),
      .ctrl_in(ctrl_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: grant at cycle G, address at G+1,
   // write beats accepted G+2.., read beats shown G+3.., idle at G+2+len.
   logic [15:0] mm [0:4095];
   int          cyc = 0;
   int          m_g, m_len, k;
   bit          m_busy = 0, m_cpu = 0, m_wr = 0;
   int          m_starve = 0;
   logic [11:0] m_base, ma;
   logic        exp_vack = 0, exp_cack = 0, exp_wait = 1;
   logic [31:0] exp_bus = 0;
   bit          cw;

   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         m_busy = 0; m_starve = 0;
         exp_vack = 0; exp_cack = 0; exp_wait = 1; exp_bus = 0;
      end else begin
         cyc++;
         exp_vack = 0; exp_cack = 0; exp_wait = 1;
         if (m_busy) begin
            k = cyc - m_g;
            if (k == 2) begin
               m_base = m_cpu ? cpu_bus_out[11:0] : vga_bus_out[11:0];
               m_len  = (m_cpu ? int'(cpu_ctrl_out[3:1])
                               : int'(vga_ctrl_out[3:1])) + 1;
               m_wr   = m_cpu && cpu_ctrl_out[0];
            end
            if (m_wr) begin
               if (k >= 3 && k <= 2 + m_len) begin
                  ma = m_base + 12'(k - 3);
                  mm[ma] = cpu_bus_out[15:0];
               end
               if (k >= 2 && k <= 1 + m_len) exp_wait = 0;
            end else if (k >= 3 && k <= 2 + m_len) begin
               ma = m_base + 12'(k - 3);
               exp_bus = {16'h0, mm[ma]};
               exp_wait = 0;
            end
            if (k >= 2 && k == 2 + m_len) m_busy = 0;
         end else if (vga_req || cpu_req) begin
            cw = cpu_req && (!vga_req || m_starve == 4);
            if (cw) begin
               exp_cack = 1; m_starve = 0;
            end else begin
               exp_vack = 1;
               if (cpu_req && m_starve < 4) m_starve++;
            end
            m_cpu = cw; m_g = cyc; m_busy = 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("vga_ack", {31'h0, vga_ack}, {31'h0, exp_vack});
      chk("cpu_ack", {31'h0, cpu_ack}, {31'h0, exp_cack});
      chk("ctrl_in", {24'h0, ctrl_in}, {31'h0, exp_wait});
      chk("bus_in", bus_in, exp_bus);
   end

   bit    log_en = 0;
   string glog = "";
   always @(negedge clk) begin
      if (log_en && vga_ack) glog = {glog, "V"};
      if (log_en && cpu_ack) glog = {glog, "C"};
   end

   task automatic wait_ack(input bit m, output bit ok);
      ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (m ? cpu_ack : vga_ack) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL ack_timeout: master %0d got no ack in 400 cycles", m);
      end
   endtask

   task automatic txn(input bit m, input logic [11:0] base, input int len,
                      input bit wr, input logic [7:0][15:0] d,
                      input bit keep, output logic [7:0][15:0] q,
                      output logic [31:0] q32);
      bit ok;
      bit ew;
      logic [31:0] a;
      logic [7:0] c;
      ew = wr && m;
      q = '0; q32 = '0;
      a = $urandom;
      a[11:0] = base;
      c = {4'b0, 3'(len - 1), wr};
      if (m) begin
         cpu_bus_out = a; cpu_ctrl_out = c; cpu_req = 1;
      end else begin
         vga_bus_out = a; vga_ctrl_out = c; vga_req = 1;
      end
      wait_ack(m, ok);
      if (!ok) begin
         if (m) cpu_req = 0; else vga_req = 0;
         return;
      end
      @(posedge clk); #1;
      if (!keep) begin
         if (m) cpu_req = 0; else vga_req = 0;
      end
      @(posedge clk); #1;
      if (ew) begin
         for (int i = 0; i < len; i++) begin
            cpu_bus_out = {16'($urandom), d[i]};
            @(posedge clk); #1;
         end
      end else begin
         if (!m && wr) vga_bus_out = 32'hDEADBEEF;
         @(negedge clk);
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            q[i] = bus_in[15:0];
            q32 = bus_in;
            chk("beat_valid", {31'h0, ctrl_in[0]}, 32'h0);
         end
      end
   endtask

   logic [7:0][15:0] d, q, dv, qv, old;
   logic [31:0]      q32, q32v;
   bit               ok;
   int               r;

   initial begin
      reset_L = 0;
      vga_req = 0; cpu_req = 0;
      vga_bus_out = 0; cpu_bus_out = 0;
      vga_ctrl_out = 0; cpu_ctrl_out = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vga_ack", {31'h0, vga_ack}, 32'h0);
      chk("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
      chk("rst_ctrl_in", {24'h0, ctrl_in}, 32'h1);
      chk("rst_bus_in", bus_in, 32'h0);
      reset_L = 1;

      for (int b = 0; b < 512; b++) begin
         for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
         txn(1, 12'(b * 8), 8, 1, d, 0, q, q32);
      end

      for (int i = 0; i < 4; i++) d[i] = 16'(16'hA1 + i);
      txn(1, 12'h010, 4, 1, d, 0, q, q32);
      txn(0, 12'h010, 4, 0, d, 0, q, q32);
      for (int i = 0; i < 4; i++)
         chk("burst_rd", {16'h0, q[i]}, 32'hA1 + i);

      log_en = 1;
      fork
         for (int i = 0; i < 8; i++)
            txn(0, 12'($urandom), 1, 0, d, 1, qv, q32v);
         for (int i = 0; i < 2; i++)
            txn(1, 12'($urandom), 1, 0, d, 1, q, q32);
      join
      vga_req = 0; cpu_req = 0;
      log_en = 0;
      n_chk++;
      if (glog != "VVVVCVVVVC") begin
         n_fail++;
         $display("FAIL grant_order: got %s expected VVVVCVVVVC", glog);
      end
      repeat (4) @(posedge clk);
      #1;

      d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
      txn(1, 12'hFFF, 3, 1, d, 0, q, q32);
      txn(1, 12'hFFF, 3, 0, d, 0, q, q32);
      chk("wrap_fff", {16'h0, q[0]}, 32'h1111);
      chk("wrap_000", {16'h0, q[1]}, 32'h2222);
      chk("wrap_001", {16'h0, q[2]}, 32'h3333);
      txn(0, 12'h000, 2, 0, d, 0, q, q32);
      chk("wrap_rd0", {16'h0, q[0]}, 32'h2222);
      chk("wrap_rd1", {16'h0, q[1]}, 32'h3333);

      d[0] = 16'h0055;
      txn(1, 12'h123, 1, 1, d, 0, q, q32);
      txn(0, 12'h123, 1, 1, d, 0, q, q32);
      chk("vga_wr_as_rd", q32, 32'h00000055);
      txn(1, 12'h123, 1, 0, d, 0, q, q32);
      chk("vga_wr_noeff", {16'h0, q[0]}, 32'h55);

      for (int i = 0; i < 8; i++) old[i] = mm[12'h200 + 12'(i)];
      d[0] = 16'hC0DE; d[1] = 16'hBEEF; d[2] = 16'hF00D;
      cpu_bus_out = 32'h0000_0200;
      cpu_ctrl_out = 8'h0F;
      cpu_req = 1;
      wait_ack(1, ok);
      @(posedge clk); #1; cpu_req = 0;
      @(posedge clk); #1; cpu_bus_out = {16'h0, d[0]};
      @(posedge clk); #1; cpu_bus_out = {16'h0, d[1]};
      @(posedge clk); #1; cpu_bus_out = {16'h0, d[2]};
      reset_L = 0;
      #1;
      chk("mid_rst_vack", {31'h0, vga_ack}, 32'h0);
      chk("mid_rst_cack", {31'h0, cpu_ack}, 32'h0);
      chk("mid_rst_ctrl", {24'h0, ctrl_in}, 32'h1);
      chk("mid_rst_bus", bus_in, 32'h0);
      @(posedge clk); #1;
      reset_L = 1;
      txn(1, 12'h200, 8, 0, d, 0, q, q32);
      chk("abort_b0", {16'h0, q[0]}, 32'hC0DE);
      chk("abort_b1", {16'h0, q[1]}, 32'hBEEF);
      for (int i = 2; i < 8; i++)
         chk("abort_keep", {16'h0, q[i]}, {16'h0, old[i]});

      for (int n = 0; n < 80; n++) begin
         for (int i = 0; i < 8; i++) begin
            d[i] = 16'($urandom);
            dv[i] = 16'($urandom);
         end
         r = $urandom_range(0, 2);
         if (r == 0)
            txn(1, 12'($urandom), $urandom_range(1, 8), 1'($urandom),
                d, 0, q, q32);
         else if (r == 1)
            txn(0, 12'($urandom), $urandom_range(1, 8), 1'($urandom),
                dv, 0, qv, q32v);
         else
            fork
               txn(1, 12'($urandom), $urandom_range(1, 8), 1'($urandom),
                   d, 0, q, q32);
               txn(0, 12'($urandom), $urandom_range(1, 8), 1'($urandom),
                   dv, 0, qv, q32v);
            join
      end

      repeat (12) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
